round_robin_lock_arbiter: RTL and testbench

//  Registered round-robin arbiter with packet lock for the switch control of each router.

---
 rtl/round_robin_lock_arbiter_pkg.sv | 26 ++
 rtl/round_robin_lock_arbiter_rr_priority_pick.sv | 44 ++++
 rtl/round_robin_lock_arbiter.sv | 129 ++++++++++++
 tb/tb_round_robin_lock_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/round_robin_lock_arbiter_pkg.sv
// ============================================================================
// round_robin_lock_arbiter_pkg
// Shared constants and state type for the router switch-control arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package round_robin_lock_arbiter_pkg;

  // Number of router ports and their index assignment
  localparam int NPORT = 5;
  localparam int EAST  = 0;
  localparam int WEST  = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;
  localparam int LOCAL = 4;

  // Arbiter state: waiting for a request, or holding a packet lock
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/round_robin_lock_arbiter_rr_priority_pick.sv
// ============================================================================
// rr_priority_pick
// Combinational masked priority encoder: returns the first set request at or
// above ptr, falling back to the lowest set request when none lies above ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
  parameter int size = 5
) (
  input  logic [size-1:0]         requests,
  input  logic [$clog2(size)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(size)-1:0] index
);

  localparam int IW = $clog2(size);

  logic          hit_hi;
  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;

  // Scan downward so the lowest qualifying index is the last one written
  always_comb begin
    hit_hi = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = size - 1; i >= 0; i--) begin
      if (requests[i]) begin
        idx_lo = IW'(i);
        if (IW'(i) >= ptr) begin
          hit_hi = 1'b1;
          idx_hi = IW'(i);
        end
      end
    end
    found = |requests;
    index = hit_hi ? idx_hi : idx_lo;
  end

endmodule

`default_nettype wire

// File: rtl/round_robin_lock_arbiter.sv
// ============================================================================
// round_robin_lock_arbiter
// Registered round-robin arbiter with packet lock. A grant is held until the
// owner pulses pkt_release, after which priority rotates past the owner.
// Optional lock timeout: define RR_ARB_LOCK_TIMEOUT_EN to force a release
// after LOCK_TIMEOUT locked cycles (timeoutEvent pulses on that cycle).
// The release input is named pkt_release because `release` is a reserved word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module round_robin_lock_arbiter
  import round_robin_lock_arbiter_pkg::*;
#(
  parameter int size         = NPORT,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [size-1:0]         requests,
  input  logic                    enable,
  input  logic                    pkt_release,
  output logic                    isOutputSelected,
  output logic [$clog2(size)-1:0] selectedOutput,
  output logic [size-1:0]         grant,
  output logic                    timeoutEvent
);

  localparam int IW = $clog2(size);

  // Reject configurations the pointer arithmetic and timeout cannot support
  if (size < 2 || LOCK_TIMEOUT < 1) begin : g_param_check
    $error("round_robin_lock_arbiter: size must be >= 2 and LOCK_TIMEOUT >= 1");
  end

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel_d;
  logic          leave;
  logic          timeout_fire;
  logic          pick_found;
  logic [IW-1:0] pick_index;

  rr_priority_pick #(
    .size (size)
  ) u_pick (
    .requests (requests),
    .ptr      (ptr_q),
    .found    (pick_found),
    .index    (pick_index)
  );

`ifdef RR_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  logic [CW-1:0] lock_cnt;

  // Count locked cycles; cleared whenever a new lock is taken
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_cnt <= '0;
    end else if (state_q == IDLE && state_d == LOCKED) begin
      lock_cnt <= '0;
    end else if (state_q == LOCKED && state_d == LOCKED) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end
`endif

  // Next-state logic: arbitrate in IDLE, wait for release (or timeout) in LOCKED
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = selectedOutput;
    leave        = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && pick_found) begin
          state_d = LOCKED;
          sel_d   = pick_index;
        end
      end
      LOCKED: begin
        if (pkt_release) begin
          leave = 1'b1;
        end
`ifdef RR_ARB_LOCK_TIMEOUT_EN
        else if (lock_cnt == CW'(LOCK_TIMEOUT)) begin
          leave        = 1'b1;
          timeout_fire = 1'b1;
        end
`endif
        if (leave) begin
          state_d = IDLE;
          // Rotate priority to the port after the owner, wrapping at size-1
          ptr_d   = (selectedOutput == IW'(size - 1)) ? '0 : selectedOutput + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and selected-index registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      selectedOutput <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      selectedOutput <= sel_d;
    end
  end

  assign isOutputSelected = (state_q == LOCKED);
  assign timeoutEvent     = timeout_fire;

  // One-hot grant decoded from the held index, zero whenever no lock is held
  always_comb begin
    grant = '0;
    if (state_q == LOCKED) begin
      grant[selectedOutput] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_round_robin_lock_arbiter.sv
// ============================================================================
// tb_round_robin_lock_arbiter
// Self-checking bench: directed vectors with literal expectations plus a
// behavioural owner/pointer model compared against the DUT every cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_robin_lock_arbiter;

  localparam int SIZE = 5;
  localparam int LTO  = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [SIZE-1:0] requests = '0;
  logic            enable = 1'b0;
  logic            rel = 1'b0;
  logic            iso;
  logic [2:0]      sel;
  logic [SIZE-1:0] grant;
  logic            tev;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: current owner (-1 = none), rotation pointer,
  // last granted index and age of the current lock in cycles
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_age   = 0;

  round_robin_lock_arbiter #(
    .size         (SIZE),
    .LOCK_TIMEOUT (LTO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .requests         (requests),
    .enable           (enable),
    .pkt_release      (rel),
    .isOutputSelected (iso),
    .selectedOutput   (sel),
    .grant            (grant),
    .timeoutEvent     (tev)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // First requester found scanning p, p+1, ... modulo SIZE
  function automatic int model_pick(input logic [SIZE-1:0] req, input int p);
    for (int k = 0; k < SIZE; k++) begin
      if (req[(p + k) % SIZE]) return (p + k) % SIZE;
    end
    return -1;
  endfunction

  function automatic int model_timeout();
`ifdef RR_ARB_LOCK_TIMEOUT_EN
    return (m_owner >= 0 && m_age == LTO && !rel) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_last  <= 0;
      m_age   <= 0;
    end else if (m_owner < 0) begin
      if (enable && requests != '0) begin
        m_owner <= model_pick(requests, m_ptr);
        m_last  <= model_pick(requests, m_ptr);
        m_age   <= 0;
      end
    end else if (rel || model_timeout() == 1) begin
      m_ptr   <= (m_owner + 1) % SIZE;
      m_owner <= -1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Compare DUT against the model mid-cycle, when inputs and outputs are stable
  always @(negedge clock) begin
    check("cmp_valid", int'(iso), (m_owner >= 0) ? 1 : 0);
    check("cmp_grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    check("cmp_sel", int'(sel), m_last);
    check("cmp_timeout", int'(tev), model_timeout());
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_release();
    rel = 1'b1;
    tick();
    rel = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_grant", int'(grant), 0);
    check("rst_valid", int'(iso), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_timeout", int'(tev), 0);
    reset = 1'b1;

    // 1: first grant from ptr=0 lands on port 2
    requests = 5'b10100;
    enable   = 1'b1;
    tick();
    check("t1_grant", int'(grant), 5'b00100);
    check("t1_sel", int'(sel), 2);
    check("t1_valid", int'(iso), 1);

    // 2: release, one IDLE cycle, then ptr=3 picks port 4
    pulse_release();
    check("t2_gap_grant", int'(grant), 0);
    check("t2_gap_valid", int'(iso), 0);
    check("t2_gap_sel_hold", int'(sel), 2);
    tick();
    check("t2_grant", int'(grant), 5'b10000);
    check("t2_sel", int'(sel), 4);

    // 3: all requesting, wrap from 4 to 0 then rotate 0..4,0
    rel = 1'b1;
    requests = 5'b11111;
    tick();
    rel = 1'b0;
    begin
      int order [6] = '{0, 1, 2, 3, 4, 0};
      for (int n = 0; n < 6; n++) begin
        tick();
        check("t3_order_sel", int'(sel), order[n]);
        check("t3_order_grant", int'(grant), 1 << order[n]);
        pulse_release();
        check("t3_gap_grant", int'(grant), 0);
      end
    end

    // 4: lock port 1, then drop requests and toggle enable
    requests = 5'b00010;
    tick();
    check("t4_grant", int'(grant), 5'b00010);
    requests = '0;
    for (int n = 0; n < 10; n++) begin
      enable = ~enable;
      tick();
      check("t4_hold_grant", int'(grant), 5'b00010);
      check("t4_hold_valid", int'(iso), 1);
    end
    enable = 1'b1;
    pulse_release();
    check("t4_released", int'(grant), 0);

    // 5: lock port 3 (ptr=2), then async reset between edges
    requests = 5'b01000;
    tick();
    check("t5_grant", int'(grant), 5'b01000);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_grant", int'(grant), 0);
    check("t5_async_valid", int'(iso), 0);
    check("t5_async_sel", int'(sel), 0);
    tick();
    reset    = 1'b1;
    requests = 5'b11000;
    tick();
    check("t5_after_rst_grant", int'(grant), 5'b01000);
    check("t5_after_rst_sel", int'(sel), 3);
    pulse_release();

`ifdef RR_ARB_LOCK_TIMEOUT_EN
    // 6: ptr=4, only port 0 requests; never release -> forced release
    requests = 5'b00001;
    tick();
    check("t6_grant", int'(grant), 5'b00001);
    requests = 5'b00011;
    for (int n = 0; n < LTO; n++) begin
      check("t6_no_timeout", int'(tev), 0);
      tick();
    end
    check("t6_timeout_pulse", int'(tev), 1);
    check("t6_timeout_grant", int'(grant), 5'b00001);
    tick();
    check("t6_after_grant", int'(grant), 0);
    check("t6_after_tev", int'(tev), 0);
    tick();
    check("t6_next_grant", int'(grant), 5'b00010);

    // Release coinciding with timeout: normal release, no event
    for (int n = 0; n < LTO; n++) tick();
    rel = 1'b1;
    #1;
    check("t6_rel_and_timeout_tev", int'(tev), 0);
    tick();
    rel = 1'b0;
    check("t6_rel_and_timeout_grant", int'(grant), 0);
    enable = 1'b0;
    tick();
`endif

    enable   = 1'b0;
    requests = '0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
